// File: rtl/dmem_mmio_responder.sv
// dmem_mmio_responder: zero-latency data RAM plus MMIO block (TOHOST, TX FIFO, STATUS, CYCLE)
module dmem_mmio_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        done,
  output logic [31:0] done_value,
  output logic        err
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  logic [31:0] ram_q [DEPTH_WORDS] = '{default: '0};
  logic [7:0]  fifo_q [FIFO_DEPTH];
  logic [PW-1:0] rd_q, wr_q;
  logic [PW:0] cnt_q, cnt_d;
  logic ovf_q, ovf_d, err_q, err_d, done_q;
  logic [31:0] done_value_q, cyc_q, cyc_d, status;
  logic is_io, illegal, wr_io, we_host, we_tx, we_st, we_cyc, empty, full, pop, push;
  logic [1:0] sel;
  logic [AW-1:0] widx;
  // Address decode, FIFO handshake and next-state values
  always_comb begin
    is_io   = mem_addr[31];
    illegal = (|mem_addr[1:0]) || (!is_io && mem_addr[30:2] >= 29'(DEPTH_WORDS));
    wr_io   = mem_we && is_io && !illegal;
    sel     = mem_addr[3:2];
    widx    = mem_addr[AW+1:2];
    we_host = wr_io && sel == 2'd0;
    we_tx   = wr_io && sel == 2'd1;
    we_st   = wr_io && sel == 2'd2;
    we_cyc  = wr_io && sel == 2'd3;
    empty   = cnt_q == '0;
    full    = cnt_q == (PW+1)'(FIFO_DEPTH);
    pop     = !empty && tx_ready;
    push    = we_tx && (!full || pop);
    cnt_d   = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
    ovf_d   = (we_tx && !push) ? 1'b1 : (we_st && mem_wdata[10]) ? 1'b0 : ovf_q;
    err_d   = illegal ? 1'b1 : (we_st && mem_wdata[11]) ? 1'b0 : err_q;
    cyc_d   = we_cyc ? '0 : done_q ? cyc_q : cyc_q + 32'd1;
    status  = {19'd0, done_q, err_q, ovf_q, full, empty, 8'(cnt_q)};
    mem_rdata = illegal ? '0 :
                !is_io ? ram_q[widx] :
                sel == 2'd0 ? done_value_q :
                sel == 2'd1 ? '0 :
                sel == 2'd2 ? status : cyc_q;
    tx_valid  = !empty;
    tx_data   = empty ? 8'd0 : fifo_q[rd_q];
  end
  assign done       = done_q;
  assign done_value = done_value_q;
  assign err        = err_q;
  // Storage arrays: RAM and FIFO slots are not touched by reset
  always_ff @(posedge clk) begin
    if (mem_we && !is_io && !illegal) ram_q[widx] <= mem_wdata;
    if (push) fifo_q[wr_q] <= mem_wdata[7:0];
  end
  // Control state: FIFO pointers, sticky flags, TOHOST and cycle counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      err_q <= 1'b0;
      done_q <= 1'b0;
      done_value_q <= '0;
      cyc_q <= '0;
    end else begin
      rd_q <= rd_q + PW'(pop);
      wr_q <= wr_q + PW'(push);
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      err_q <= err_d;
      cyc_q <= cyc_d;
      if (we_host && !done_q) begin
        done_q <= 1'b1;
        done_value_q <= mem_wdata;
      end
    end
  end
endmodule

// File: tb/tb_dmem_mmio_responder.sv
// tb_dmem_mmio_responder: directed scenarios plus randomized traffic against a queue/array reference model
module tb_dmem_mmio_responder;
  logic clk = 0, reset = 1, mem_we = 0, tx_ready = 0;
  logic [31:0] mem_addr = 0, mem_wdata = 0, mem_rdata, done_value;
  logic tx_valid, done, err;
  logic [7:0] tx_data;
  int errors = 0, checks = 0;
  logic [31:0] mram [64];
  logic [7:0] mq [$];
  bit merr = 0, movf = 0;

  dmem_mmio_responder #(.DEPTH_WORDS(64), .FIFO_DEPTH(8)) dut (
    .clk(clk), .reset(reset), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .done(done), .done_value(done_value), .err(err));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    mem_we = 1; mem_addr = a; mem_wdata = d;
    step();
    if (!a[31] && a[1:0] == 2'b0 && a[30:2] < 64) mram[a[7:2]] = d;
    mem_we = 0; mem_addr = 0; mem_wdata = 0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    mem_addr = a;
    #1;
    d = mem_rdata;
    mem_addr = 0;
  endtask

  function automatic logic [31:0] mstatus();
    return {19'd0, 1'b0, merr, movf, mq.size() == 8, mq.size() == 0, 8'(mq.size())};
  endfunction

  task automatic test_reset();
    logic [31:0] v, c0;
    #2;
    checks++;
    if ({tx_valid, tx_data, done, done_value, err} !== 43'd0) begin
      errors++; $display("FAIL reset_outputs: got %h want 0", {tx_valid, tx_data, done, done_value, err});
    end
    repeat (2) step();
    reset = 0;
    checks++;
    if ({tx_valid, tx_data, done, done_value, err} !== 43'd0) begin
      errors++; $display("FAIL post_reset_outputs: got %h want 0", {tx_valid, tx_data, done, done_value, err});
    end
    rd(32'h8000_0008, v);
    checks++;
    if (v !== 32'h100) begin errors++; $display("FAIL reset_status: got %h want %h", v, 32'h100); end
    rd(32'h8000_000C, c0);
    step();
    rd(32'h8000_000C, v);
    checks++;
    if (v !== c0 + 1) begin errors++; $display("FAIL cycle_increment: got %h want %h", v, c0 + 1); end
  endtask

  task automatic test_ram();
    logic [31:0] v;
    mem_we = 1; mem_addr = 32'h10; mem_wdata = 32'hDEAD_BEEF;
    #1;
    checks++;
    if (mem_rdata !== 32'h0) begin errors++; $display("FAIL ram_same_cycle_old: got %h want 0", mem_rdata); end
    step();
    mram[4] = 32'hDEAD_BEEF;
    mem_we = 0; mem_addr = 0; mem_wdata = 0;
    rd(32'h10, v);
    checks++;
    if (v !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ram_readback: got %h want DEADBEEF", v); end
    for (int i = 0; i < 4; i++) begin
      int w;
      w = $urandom_range(5, 63);
      wr(32'(w) << 2, $urandom);
      rd(32'(w) << 2, v);
      checks++;
      if (v !== mram[w]) begin errors++; $display("FAIL ram_random w=%0d: got %h want %h", w, v, mram[w]); end
    end
  endtask

  task automatic test_tx_overflow();
    logic [31:0] v;
    tx_ready = 0;
    for (int i = 0; i < 9; i++) wr(32'h8000_0004, 32'h41 + i);
    rd(32'h8000_0008, v);
    checks++;
    if (v !== 32'h608) begin errors++; $display("FAIL overflow_status: got %h want 608", v); end
    tx_ready = 1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== 8'(32'h41 + i)) begin
        errors++; $display("FAIL drain[%0d]: got v=%b d=%h want v=1 d=%h", i, tx_valid, tx_data, 8'(32'h41 + i));
      end
      step();
    end
    checks++;
    if (tx_valid !== 1'b0 || tx_data !== 8'h0) begin
      errors++; $display("FAIL drain_empty: got v=%b d=%h want v=0 d=00", tx_valid, tx_data);
    end
    tx_ready = 0;
    rd(32'h8000_0008, v);
    checks++;
    if (v !== 32'h500) begin errors++; $display("FAIL overflow_sticky: got %h want 500", v); end
    wr(32'h8000_0008, 32'h400);
    rd(32'h8000_0008, v);
    checks++;
    if (v !== 32'h100) begin errors++; $display("FAIL overflow_w1c: got %h want 100", v); end
  endtask

  task automatic test_full_push_pop();
    logic [31:0] v;
    logic [7:0] exp [8];
    tx_ready = 0;
    for (int i = 0; i < 8; i++) wr(32'h8000_0004, 32'h61 + i);
    tx_ready = 1; mem_we = 1; mem_addr = 32'h8000_0004; mem_wdata = 32'h5A;
    step();
    tx_ready = 0; mem_we = 0; mem_addr = 0; mem_wdata = 0;
    rd(32'h8000_0008, v);
    checks++;
    if (v !== 32'h208) begin errors++; $display("FAIL full_push_pop_status: got %h want 208", v); end
    for (int i = 0; i < 7; i++) exp[i] = 8'(32'h62 + i);
    exp[7] = 8'h5A;
    tx_ready = 1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== exp[i]) begin
        errors++; $display("FAIL full_drain[%0d]: got v=%b d=%h want v=1 d=%h", i, tx_valid, tx_data, exp[i]);
      end
      step();
    end
    tx_ready = 0;
    checks++;
    if (tx_valid !== 1'b0) begin errors++; $display("FAIL full_drain_empty: got %b want 0", tx_valid); end
  endtask

  task automatic test_illegal();
    logic [31:0] v;
    wr(32'h0, 32'h1111_1111);
    mem_addr = 32'h2;
    #1;
    checks++;
    if (mem_rdata !== 32'h0 || err !== 1'b0) begin
      errors++; $display("FAIL misaligned_read: got rdata=%h err=%b want 0/0", mem_rdata, err);
    end
    step();
    mem_addr = 0;
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL misaligned_err: got %b want 1", err); end
    wr(32'h8000_0008, 32'h800);
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL err_w1c: got %b want 0", err); end
    wr(32'h100, 32'hCAFE_F00D);
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL oob_write_err: got %b want 1", err); end
    rd(32'h0, v);
    checks++;
    if (v !== 32'h1111_1111) begin errors++; $display("FAIL oob_write_ignored: got %h want 11111111", v); end
    rd(32'h100, v);
    checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL oob_read: got %h want 0", v); end
    wr(32'h8000_0008, 32'h800);
    rd(32'h8000_0008, v);
    checks++;
    if (v !== 32'h100) begin errors++; $display("FAIL err_cleared_status: got %h want 100", v); end
  endtask

  task automatic test_cycle_clear();
    logic [31:0] v;
    wr(32'h8000_000C, 32'h1234);
    rd(32'h8000_000C, v);
    checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL cycle_clear: got %h want 0", v); end
    repeat (5) step();
    rd(32'h8000_000C, v);
    checks++;
    if (v !== 32'h5) begin errors++; $display("FAIL cycle_count5: got %h want 5", v); end
  endtask

  task automatic test_tohost();
    logic [31:0] v, c1;
    wr(32'h8000_0000, 32'h2A);
    checks++;
    if (done !== 1'b1 || done_value !== 32'h2A) begin
      errors++; $display("FAIL tohost_set: got done=%b val=%h want 1/2a", done, done_value);
    end
    rd(32'h8000_000C, c1);
    repeat (3) step();
    rd(32'h8000_000C, v);
    checks++;
    if (v !== c1) begin errors++; $display("FAIL cycle_frozen: got %h want %h", v, c1); end
    wr(32'h8000_0000, 32'h55);
    rd(32'h8000_0000, v);
    checks++;
    if (done_value !== 32'h2A || v !== 32'h2A) begin
      errors++; $display("FAIL tohost_second: got val=%h rd=%h want 2a", done_value, v);
    end
    rd(32'h8000_0008, v);
    checks++;
    if (v !== 32'h1100) begin errors++; $display("FAIL done_status: got %h want 1100", v); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] v;
    wr(32'h20, 32'h1234_5678);
    tx_ready = 0;
    for (int i = 0; i < 3; i++) wr(32'h8000_0004, 32'h70 + i);
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h70) begin
      errors++; $display("FAIL queued_before_reset: got v=%b d=%h want 1/70", tx_valid, tx_data);
    end
    #2;
    reset = 1;
    #1;
    checks++;
    if (tx_valid !== 1'b0 || done !== 1'b0 || done_value !== 32'h0 || tx_data !== 8'h0) begin
      errors++; $display("FAIL async_reset: got v=%b d=%h done=%b val=%h want 0", tx_valid, tx_data, done, done_value);
    end
    tx_ready = 1;
    repeat (2) step();
    reset = 0;
    tx_ready = 0;
    rd(32'h8000_0008, v);
    checks++;
    if (v !== 32'h100) begin errors++; $display("FAIL reset_mid_status: got %h want 100", v); end
    rd(32'h20, v);
    checks++;
    if (v !== 32'h1234_5678) begin errors++; $display("FAIL ram_kept_20: got %h want 12345678", v); end
    rd(32'h10, v);
    checks++;
    if (v !== mram[4]) begin errors++; $display("FAIL ram_kept_10: got %h want %h", v, mram[4]); end
  endtask

  task automatic test_random();
    mq.delete(); merr = 0; movf = 0;
    for (int it = 0; it < 400; it++) begin
      int op, w;
      logic [31:0] d, exp;
      bit pop;
      op = $urandom_range(0, 5);
      w = $urandom_range(0, 63);
      d = $urandom;
      tx_ready = 1'($urandom_range(0, 1));
      mem_we = 0; mem_wdata = d; exp = 0;
      case (op)
        0: begin mem_we = 1; mem_addr = 32'(w) << 2; exp = mram[w]; end
        1: begin mem_addr = 32'(w) << 2; exp = mram[w]; end
        2: begin mem_we = 1; mem_addr = 32'h8000_0004 | (32'($urandom) & 32'h7FFF_FFF0); end
        3: begin mem_addr = 32'h8000_0008; exp = mstatus(); end
        4: begin d = d & 32'hC00; mem_wdata = d; mem_we = 1; mem_addr = 32'h8000_0008; exp = mstatus(); end
        default: begin
          mem_we = 1'($urandom_range(0, 1));
          mem_addr = $urandom_range(0, 1) ? ((32'(w) << 2) | 32'($urandom_range(1, 3))) : (32'(w + 64) << 2);
        end
      endcase
      #1;
      checks++;
      if (mem_rdata !== exp) begin errors++; $display("FAIL rand_rdata it=%0d op=%0d: got %h want %h", it, op, mem_rdata, exp); end
      checks++;
      if (tx_valid !== (mq.size() != 0) || tx_data !== (mq.size() != 0 ? mq[0] : 8'h0)) begin
        errors++; $display("FAIL rand_tx it=%0d: got v=%b d=%h want v=%b d=%h", it, tx_valid, tx_data,
                           mq.size() != 0, mq.size() != 0 ? mq[0] : 8'h0);
      end
      pop = mq.size() != 0 && tx_ready;
      if (pop) void'(mq.pop_front());
      if (op == 2) begin
        if (mq.size() < 8) mq.push_back(d[7:0]);
        else movf = 1;
      end
      if (op == 0) mram[w] = d;
      if (op == 4 && d[10]) movf = 0;
      if (op == 5) merr = 1;
      else if (op == 4 && d[11]) merr = 0;
      step();
    end
    mem_we = 0; mem_addr = 0; mem_wdata = 0; tx_ready = 0;
    checks++;
    if (err !== merr || done !== 1'b0) begin errors++; $display("FAIL rand_final: got err=%b done=%b want err=%b done=0", err, done, merr); end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mram[i] = 0;
    test_reset();
    test_ram();
    test_tx_overflow();
    test_full_push_pop();
    test_illegal();
    test_cycle_clear();
    test_tohost();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dmem_mmio_responder.md
DMEM_MMIO_RESPONDER -- requirements
Module: dmem_mmio_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 64, meaning RAM size in 32-bit words (power of two, 4..4096).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, meaning TX FIFO entries (power of two, 2..128).
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port mem_we  input  1  store strobe from the core MEM stage.
REQ-006 SHALL have port mem_addr  input  32  byte address from the core.
REQ-007 SHALL have port mem_wdata  input  32  store data.
REQ-008 SHALL have port mem_rdata  output  32  load data, combinational on mem_addr.
REQ-009 SHALL have port tx_valid  output  1  TX FIFO head valid.
REQ-010 SHALL have port tx_data  output  8  TX FIFO head byte.
REQ-011 SHALL have port tx_ready  input  1  downstream accepts head.
REQ-012 SHALL have port done  output  1  sticky test-complete flag.
REQ-013 SHALL have port done_value  output  32  value written to TOHOST.
REQ-014 SHALL have port err  output  1  sticky access-error flag.

Function
REQ-015 SHALL decode: mem_addr[31]=0 -> RAM; mem_addr[31]=1 -> MMIO at offset mem_addr[3:0]; MMIO bits [30:4] ignored.
REQ-016 SHALL treat an access as illegal when mem_addr[1:0]!=0, or RAM word index mem_addr[30:2] >= DEPTH_WORDS.
REQ-017 SHALL, for illegal accesses: drive mem_rdata=0; ignore the write; set err at the next edge (reads and writes alike).
REQ-018 SHALL return RAM[mem_addr>>2] on mem_rdata in the same cycle (zero-latency read), since the core samples it at the MEM/WB edge.
REQ-019 SHALL commit RAM writes at the rising edge where mem_we=1; a same-cycle read of that address returns the old data.
REQ-020 SHALL implement MMIO 0x0 TOHOST: write when done=0 sets done=1 and done_value=mem_wdata; writes when done=1 ignored; read returns done_value.
REQ-021 SHALL implement MMIO 0x4 TXDATA: write pushes mem_wdata[7:0]; read returns 0.
REQ-022 SHALL implement MMIO 0x8 STATUS read: [7:0] count, [8] empty, [9] full, [10] overflow, [11] err, [12] done, rest 0; write: W1C of overflow (bit10) and err (bit11).
REQ-023 SHALL implement MMIO 0xC CYCLE: read returns cycle counter; write clears it to 0 at that edge (clear has priority over increment).
REQ-024 SHALL increment CYCLE by 1 each clock while done=0, freezing once done=1; wrap 0xFFFFFFFF -> 0.
REQ-025 SHALL drive tx_valid = (count != 0) and tx_data = head entry, or 0 when empty.
REQ-026 SHALL pop the head at the edge where tx_valid && tx_ready.
REQ-027 SHALL accept a push when count < FIFO_DEPTH, or when a pop occurs in the same cycle (full FIFO with simultaneous pop+push stays full, order preserved).
REQ-028 SHALL drop a rejected push, leave contents unchanged, and set overflow sticky.
REQ-029 SHALL keep count in 0..FIFO_DEPTH with wrap-around read/write pointers; push+pop on non-full non-empty leaves count unchanged.
REQ-030 SHALL give a same-edge error/overflow set priority over a W1C clear of that bit.

Reset
REQ-031 SHALL on reset asynchronously clear: FIFO pointers and count, overflow, err, done, done_value, cycle counter.
REQ-032 SHALL therefore drive tx_valid=0, tx_data=0, done=0, done_value=0, err=0 during and immediately after reset.
REQ-033 SHALL leave RAM contents unaffected by reset; RAM initialises to all-zero at time 0.
REQ-034 SHALL discard FIFO contents if reset asserts mid-drain; no partial pop occurs.

Verification
REQ-035 SHALL cover: write 0xDEADBEEF to 0x00000010, then read 0x10 -> mem_rdata=0xDEADBEEF; same-cycle read during write shows old value 0.
REQ-036 SHALL cover: tx_ready=0, push 9 bytes 0x41..0x49 (FIFO_DEPTH=8) -> STATUS=0x0000_0608 (count 8, full, overflow); raise tx_ready -> bytes 0x41..0x48 drained in order, then tx_valid=0.
REQ-037 SHALL cover: FIFO full, tx_ready=1, push 0x5A in same cycle -> count stays 8, overflow stays 0, 0x5A drained last.
REQ-038 SHALL cover: read 0x00000002 and write 0x00000100 (DEPTH 64) -> mem_rdata=0, RAM unchanged, err=1; write STATUS 0x800 -> err=0.
REQ-039 SHALL cover: write 0x2A to 0x80000000 -> done=1, done_value=0x2A, CYCLE frozen; second write 0x55 -> done_value stays 0x2A.
REQ-040 SHALL cover: reset asserted with 3 bytes queued and done=1 -> tx_valid=0, done=0, STATUS=0x100, RAM data preserved.
